dmiss_sched: RTL and testbench



---
 rtl/dmiss_sched.sv | 164 ++++++++++++++++
 tb/tb_dmiss_sched.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmiss_sched.sv
// Miss-drain scheduler: drains filled miss-CAM entries round-robin into the L2 request channel,
// tracks outstanding tags and pulses unlock once a locked CAM has fully drained.
module dmiss_sched #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned ADDR_W  = 37,
    parameter int unsigned MAX_OUT = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ENTRIES-1:0] filled,
    input  logic              locked,
    output logic              ins_en,
    output logic [TAG_W-1:0]  ins_req,
    input  logic [ADDR_W-1:0] ins_addr,
    output logic              l2_req_vld,
    input  logic              l2_req_rdy,
    output logic [ADDR_W-1:0] l2_req_addr,
    output logic [TAG_W-1:0]  l2_req_tag,
    input  logic              l2_rsp_vld,
    input  logic [TAG_W-1:0]  l2_rsp_tag,
    output logic              unlock,
    output logic [TAG_W:0]    out_cnt,
    output logic              err
);

    localparam logic [TAG_W:0] MaxOut = (TAG_W+1)'(MAX_OUT);

    typedef enum logic [1:0] {StIdle, StPick, StIssue, StUnlk} state_e;

    state_e              state_q, state_d;
    logic [TAG_W-1:0]    rr_q, rr_d;
    logic [TAG_W-1:0]    sel_q, sel_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ENTRIES-1:0]  pend_q, pend_d;
    logic [TAG_W:0]      cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                ins_en_q, ins_en_d;
    logic                vld_q, vld_d;
    logic                unlock_q, unlock_d;

    logic [TAG_W-1:0]    sel;
    logic [TAG_W-1:0]    idx;
    logic                found;
    logic                any_filled;
    logic                handshake;
    logic                rsp_hit;

    // Round-robin search: first filled entry at or above rr, wrapping.
    always_comb begin
        sel   = rr_q;
        idx   = rr_q;
        found = 1'b0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            idx = rr_q + TAG_W'(i);
            if (!found && filled[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    assign any_filled = |filled;
    assign handshake  = (state_q == StIssue) && l2_req_rdy;
    assign rsp_hit    = l2_rsp_vld && pend_q[l2_rsp_tag];

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        sel_d   = sel_q;
        tag_d   = tag_q;
        addr_d  = addr_q;
        unique case (state_q)
            StIdle: begin
                if (any_filled && (cnt_q < MaxOut)) begin
                    state_d = StPick;
                end else if (locked && !any_filled && (pend_q == '0) && !l2_rsp_vld) begin
                    state_d = StUnlk;
                end
            end
            StPick: begin
                addr_d  = ins_addr;
                tag_d   = sel_q;
                rr_d    = sel_q + TAG_W'(1);
                state_d = StIssue;
            end
            StIssue: begin
                if (l2_req_rdy) begin
                    // cnt_q < MaxOut here, so the +1 cannot overflow.
                    if (any_filled && ((cnt_q + (TAG_W+1)'(1)) < MaxOut)) begin
                        state_d = StPick;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StUnlk: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Selection is registered on entry to PICK so ins_req never depends on live inputs.
        if (state_d == StPick && state_q != StPick) begin
            sel_d = sel;
        end
    end

    always_comb begin
        pend_d = pend_q;
        if (rsp_hit) begin
            pend_d[l2_rsp_tag] = 1'b0;
        end
        if (handshake) begin
            pend_d[tag_q] = 1'b1;
        end
        err_d = err_q | (l2_rsp_vld && !pend_q[l2_rsp_tag]);
        cnt_d = cnt_q;
        if (handshake && !rsp_hit) begin
            cnt_d = cnt_q + (TAG_W+1)'(1);
        end else if (!handshake && rsp_hit) begin
            cnt_d = cnt_q - (TAG_W+1)'(1);
        end
        ins_en_d = (state_d == StPick);
        vld_d    = (state_d == StIssue);
        unlock_d = (state_d == StUnlk);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            rr_q     <= '0;
            sel_q    <= '0;
            tag_q    <= '0;
            addr_q   <= '0;
            pend_q   <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            ins_en_q <= 1'b0;
            vld_q    <= 1'b0;
            unlock_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            sel_q    <= sel_d;
            tag_q    <= tag_d;
            addr_q   <= addr_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            ins_en_q <= ins_en_d;
            vld_q    <= vld_d;
            unlock_q <= unlock_d;
        end
    end

    assign ins_en      = ins_en_q;
    assign ins_req     = sel_q;
    assign l2_req_vld  = vld_q;
    assign l2_req_addr = addr_q;
    assign l2_req_tag  = tag_q;
    assign unlock      = unlock_q;
    assign out_cnt     = cnt_q;
    assign err         = err_q;

endmodule

// File: tb/tb_dmiss_sched.sv
// Directed bench for dmiss_sched with a small miss-CAM model (read port, fill clear, lock clear).
module tb_dmiss_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] filled;
    logic        locked;
    logic        ins_en;
    logic [3:0]  ins_req;
    logic [36:0] ins_addr;
    logic        l2_req_vld;
    logic        l2_req_rdy;
    logic [36:0] l2_req_addr;
    logic [3:0]  l2_req_tag;
    logic        l2_rsp_vld;
    logic [3:0]  l2_rsp_tag;
    logic        unlock;
    logic [4:0]  out_cnt;
    logic        err;

    logic [36:0] addr_mem [16];
    logic [3:0]  iss_tags [$];
    int          iss_cyc [$];
    int          cyc;
    int          unlock_pulses;
    int          checks = 0;
    int          errors = 0;

    dmiss_sched #(
        .ENTRIES(16),
        .TAG_W  (4),
        .ADDR_W (37),
        .MAX_OUT(8)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .filled     (filled),
        .locked     (locked),
        .ins_en     (ins_en),
        .ins_req    (ins_req),
        .ins_addr   (ins_addr),
        .l2_req_vld (l2_req_vld),
        .l2_req_rdy (l2_req_rdy),
        .l2_req_addr(l2_req_addr),
        .l2_req_tag (l2_req_tag),
        .l2_rsp_vld (l2_rsp_vld),
        .l2_rsp_tag (l2_rsp_tag),
        .unlock     (unlock),
        .out_cnt    (out_cnt),
        .err        (err)
    );

    always #5 clk = ~clk;

    always_comb ins_addr = addr_mem[ins_req];

    // One clock; the CAM model clears the picked entry and the lock at the edge.
    task automatic tick();
        logic       pick;
        logic       unl;
        logic [3:0] pt;
        pick = ins_en;
        pt   = ins_req;
        unl  = unlock;
        if (l2_req_vld && l2_req_rdy) begin
            iss_tags.push_back(l2_req_tag);
            iss_cyc.push_back(cyc);
        end
        if (unl) unlock_pulses++;
        @(posedge clk);
        #1;
        cyc++;
        if (pick) filled[pt] = 1'b0;
        if (unl) locked = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n      = 1'b0;
        filled     = '0;
        locked     = 1'b0;
        l2_req_rdy = 1'b0;
        l2_rsp_vld = 1'b0;
        l2_rsp_tag = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        iss_tags.delete();
        iss_cyc.delete();
        cyc           = 0;
        unlock_pulses = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({ins_en, ins_req, l2_req_vld, l2_req_addr, l2_req_tag, unlock, out_cnt, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: en=%b req=%0d vld=%b addr=%h tag=%0d unl=%b cnt=%0d err=%b want all 0",
                     ins_en, ins_req, l2_req_vld, l2_req_addr, l2_req_tag, unlock, out_cnt, err);
        end
        tick();
        tick();
        checks++;
        if (ins_en !== 1'b0 || l2_req_vld !== 1'b0) begin
            errors++;
            $display("FAIL idle_quiet: en=%b vld=%b want 0 0", ins_en, l2_req_vld);
        end
    endtask

    task automatic test_first_issue();
        apply_reset();
        addr_mem[0] = 37'h1_2345_6780;
        l2_req_rdy  = 1'b1;
        filled      = 16'h0001;
        tick();
        checks++;
        if (ins_en !== 1'b1 || ins_req !== 4'd0 || l2_req_vld !== 1'b0) begin
            errors++;
            $display("FAIL first_pick: en=%b req=%0d vld=%b want 1 0 0", ins_en, ins_req, l2_req_vld);
        end
        tick();
        checks++;
        if (l2_req_vld !== 1'b1 || l2_req_addr !== 37'h1_2345_6780 || l2_req_tag !== 4'd0) begin
            errors++;
            $display("FAIL first_issue: vld=%b addr=%h tag=%0d want 1 123456780 0",
                     l2_req_vld, l2_req_addr, l2_req_tag);
        end
        tick();
        checks++;
        if (out_cnt !== 5'd1 || l2_req_vld !== 1'b0) begin
            errors++;
            $display("FAIL first_cnt: cnt=%0d vld=%b want 1 0", out_cnt, l2_req_vld);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        l2_req_rdy = 1'b1;
        filled     = 16'h8003;
        for (int i = 0; i < 12; i++) tick();
        checks++;
        if (iss_tags.size() != 3) begin
            errors++;
            $display("FAIL rr_count: issues=%0d want 3", iss_tags.size());
        end else begin
            checks++;
            if (iss_tags[0] !== 4'd0 || iss_tags[1] !== 4'd1 || iss_tags[2] !== 4'd15) begin
                errors++;
                $display("FAIL rr_order: tags=%0d,%0d,%0d want 0,1,15",
                         iss_tags[0], iss_tags[1], iss_tags[2]);
            end
            checks++;
            if (iss_cyc[1] - iss_cyc[0] != 2 || iss_cyc[2] - iss_cyc[1] != 2) begin
                errors++;
                $display("FAIL rr_rate: cycles=%0d,%0d,%0d want spacing 2",
                         iss_cyc[0], iss_cyc[1], iss_cyc[2]);
            end
        end
        checks++;
        if (out_cnt !== 5'd3) begin
            errors++;
            $display("FAIL rr_cnt: cnt=%0d want 3", out_cnt);
        end
    endtask

    task automatic test_max_out();
        apply_reset();
        l2_req_rdy = 1'b1;
        filled     = 16'h0FFF;
        for (int i = 0; i < 30; i++) tick();
        checks++;
        if (iss_tags.size() != 8 || out_cnt !== 5'd8 || ins_en !== 1'b0) begin
            errors++;
            $display("FAIL max_stall: issues=%0d cnt=%0d en=%b want 8 8 0",
                     iss_tags.size(), out_cnt, ins_en);
        end
        l2_rsp_vld = 1'b1;
        l2_rsp_tag = 4'd2;
        tick();
        l2_rsp_vld = 1'b0;
        checks++;
        if (out_cnt !== 5'd7 || ins_en !== 1'b0) begin
            errors++;
            $display("FAIL max_free: cnt=%0d en=%b want 7 0", out_cnt, ins_en);
        end
        tick();
        checks++;
        if (ins_en !== 1'b1 || ins_req !== 4'd8) begin
            errors++;
            $display("FAIL max_resume: en=%b req=%0d want 1 8", ins_en, ins_req);
        end
        tick();
        tick();
        checks++;
        if (iss_tags.size() != 9 || out_cnt !== 5'd8) begin
            errors++;
            $display("FAIL max_ninth: issues=%0d cnt=%0d want 9 8", iss_tags.size(), out_cnt);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        addr_mem[5] = 37'h0_0ABC_DEF0;
        l2_req_rdy  = 1'b0;
        filled      = 16'h0020;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (l2_req_vld !== 1'b1 || l2_req_addr !== 37'h0_0ABC_DEF0 || l2_req_tag !== 4'd5) begin
                errors++;
                $display("FAIL bp_hold[%0d]: vld=%b addr=%h tag=%0d want 1 00abcdef0 5",
                         i, l2_req_vld, l2_req_addr, l2_req_tag);
            end
            tick();
        end
        l2_req_rdy = 1'b1;
        tick();
        tick();
        checks++;
        if (iss_tags.size() != 1 || l2_req_vld !== 1'b0 || out_cnt !== 5'd1) begin
            errors++;
            $display("FAIL bp_single: issues=%0d vld=%b cnt=%0d want 1 0 1",
                     iss_tags.size(), l2_req_vld, out_cnt);
        end
    endtask

    task automatic test_unlock();
        apply_reset();
        l2_req_rdy = 1'b1;
        locked     = 1'b1;
        filled     = 16'h0111;
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (out_cnt !== 5'd3 || unlock !== 1'b0) begin
            errors++;
            $display("FAIL unl_pending: cnt=%0d unl=%b want 3 0", out_cnt, unlock);
        end
        for (int i = 0; i < 3; i++) begin
            l2_rsp_vld = 1'b1;
            l2_rsp_tag = 4'(i * 4);
            tick();
        end
        l2_rsp_vld = 1'b0;
        checks++;
        if (unlock !== 1'b0 || out_cnt !== 5'd0) begin
            errors++;
            $display("FAIL unl_early: unl=%b cnt=%0d want 0 0", unlock, out_cnt);
        end
        tick();
        checks++;
        if (unlock !== 1'b1 || ins_en !== 1'b0 || l2_req_vld !== 1'b0) begin
            errors++;
            $display("FAIL unl_pulse: unl=%b en=%b vld=%b want 1 0 0", unlock, ins_en, l2_req_vld);
        end
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (unlock_pulses != 1 || unlock !== 1'b0) begin
            errors++;
            $display("FAIL unl_single: pulses=%0d unl=%b want 1 0", unlock_pulses, unlock);
        end
    endtask

    task automatic test_err_and_reset();
        apply_reset();
        l2_rsp_vld = 1'b1;
        l2_rsp_tag = 4'd7;
        tick();
        l2_rsp_vld = 1'b0;
        tick();
        tick();
        checks++;
        if (err !== 1'b1 || out_cnt !== 5'd0) begin
            errors++;
            $display("FAIL err_stray: err=%b cnt=%0d want 1 0", err, out_cnt);
        end
        l2_req_rdy = 1'b1;
        filled     = 16'h0004;
        tick();
        tick();
        l2_rsp_vld = 1'b1;
        l2_rsp_tag = 4'd2;
        tick();
        l2_rsp_vld = 1'b0;
        checks++;
        if (err !== 1'b1 || out_cnt !== 5'd1) begin
            errors++;
            $display("FAIL err_same_tag: err=%b cnt=%0d want 1 1", err, out_cnt);
        end
        addr_mem[3] = 37'h1_0000_0003;
        l2_req_rdy  = 1'b0;
        filled      = 16'h0008;
        tick();
        tick();
        checks++;
        if (l2_req_vld !== 1'b1 || l2_req_tag !== 4'd3) begin
            errors++;
            $display("FAIL err_issue: vld=%b tag=%0d want 1 3", l2_req_vld, l2_req_tag);
        end
        #2;
        rst_n  = 1'b0;
        filled = '0;
        #1;
        checks++;
        if ({ins_en, ins_req, l2_req_vld, l2_req_addr, l2_req_tag, unlock, out_cnt, err} !== '0) begin
            errors++;
            $display("FAIL async_reset: en=%b req=%0d vld=%b addr=%h tag=%0d unl=%b cnt=%0d err=%b want all 0",
                     ins_en, ins_req, l2_req_vld, l2_req_addr, l2_req_tag, unlock, out_cnt, err);
        end
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        l2_rsp_vld = 1'b1;
        l2_rsp_tag = 4'd3;
        tick();
        l2_rsp_vld = 1'b0;
        checks++;
        if (err !== 1'b1 || out_cnt !== 5'd0) begin
            errors++;
            $display("FAIL late_rsp: err=%b cnt=%0d want 1 0", err, out_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) addr_mem[i] = 37'h10_0000_0000 + 37'(i);
        test_reset();
        test_first_issue();
        test_round_robin();
        test_max_out();
        test_backpressure();
        test_unlock();
        test_err_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
